// File: rtl/dbus_pkg.sv
// Shared types for the core data-bus (dbus) handshake.
//   msize_t     : access size encoding (1/2/4/8 bytes)
//   dbus_req_t  : valid, addr[63:0], size, strobe[7:0], data[63:0]
//   dbus_resp_t : addr_ok, data_ok, data[63:0]
package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder.sv
// Simple SRAM model answering the core's dbus with a fixed latency.
// One access is outstanding at a time: IDLE accepts, WAIT counts down,
// RESP presents addr_ok/data_ok for a single cycle. Writes commit at the
// end of the RESP cycle; faulty accesses (out of range or misaligned)
// complete with err=1 and data=0 and never touch memory.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   dreq  : request from the memory stage (dbus_req_t)
//   dresp : response (dbus_resp_t), registered
//   err   : one-cycle pulse alongside data_ok for a faulty access
module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [63:0] mem [MEM_WORDS];

  logic [1:0]    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          latch_en;

  // Request captured at acceptance
  logic [AW-1:0] idx_q;
  logic [7:0]    strobe_q;
  logic [63:0]   wdata_q;
  logic          fault_q;

  // Registered response
  logic          resp_ok;
  logic          resp_err;
  logic [63:0]   resp_data;

  // Decode of the live request (only consumed when it is being accepted)
  logic [60:0]   word_off;
  logic          misaligned;
  logic          req_fault;

  assign word_off = 61'((dreq.addr - BASE_ADDR) >> 3);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    misaligned = 1'b0;
    case (dreq.size)
      MSIZE2:  misaligned = dreq.addr[0];
      MSIZE4:  misaligned = |dreq.addr[1:0];
      MSIZE8:  misaligned = |dreq.addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_fault = (dreq.addr < BASE_ADDR) || (word_off >= 61'(MEM_WORDS)) || misaligned;

  // With LATENCY=1 the response is loaded on the acceptance edge itself,
  // before the capture registers hold the request, so take it from dreq.
  logic          src_fault;
  logic          src_read;
  logic [AW-1:0] src_idx;

  assign src_fault = (state == IDLE) ? req_fault           : fault_q;
  assign src_read  = (state == IDLE) ? (dreq.strobe == '0) : (strobe_q == '0);
  assign src_idx   = (state == IDLE) ? word_off[AW-1:0]    : idx_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          latch_en = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          // Initiator flushed the access: abandon it silently.
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic enter_resp;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      fault_q   <= 1'b0;
      resp_ok   <= 1'b0;
      resp_err  <= 1'b0;
      resp_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch_en) begin
        idx_q    <= word_off[AW-1:0];
        strobe_q <= dreq.strobe;
        wdata_q  <= dreq.data;
        fault_q  <= req_fault;
      end
      resp_ok  <= enter_resp;
      resp_err <= enter_resp && src_fault;
      // A write commits at the end of the previous RESP, at least one IDLE
      // cycle earlier, so this read always sees the latest contents.
      resp_data <= (enter_resp && !src_fault && src_read) ? mem[src_idx] : '0;
    end
  end

  // NOTE: the memory array has no reset; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == RESP && !fault_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dresp = '{addr_ok: resp_ok, data_ok: resp_ok, data: resp_data};
  assign err   = resp_err;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: one instance with LATENCY=2,
// one with LATENCY=1 for back-to-back throughput. Stimulus pushes the
// expected response (data, err, cycle it is due); a negedge monitor pops
// and compares whenever data_ok is seen, and otherwise requires idle zeros.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq0, dreq1;
  dbus_resp_t dresp0, dresp1;
  logic       err0, err1;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic prev_ok [2] = '{1'b0, 1'b0};

  dbus_sram_responder u_dut0 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq0),
    .dresp (dresp0),
    .err   (err0)
  );

  dbus_sram_responder #(.LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq1),
    .dresp (dresp1),
    .err   (err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input int w, input dbus_resp_t r, input logic e);
    exp_t x;
    if (r.data_ok) begin
      check($sformatf("dut%0d consecutive data_ok", w), 80'(prev_ok[w]), 80'd0);
      if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
        check($sformatf("dut%0d unexpected data_ok", w), 80'(r.data_ok), 80'd0);
      end else begin
        if (w == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        check($sformatf("dut%0d data", w), 80'(r.data), 80'(x.data));
        check($sformatf("dut%0d err", w), 80'(e), 80'(x.err));
        check($sformatf("dut%0d addr_ok", w), 80'(r.addr_ok), 80'd1);
        check($sformatf("dut%0d response cycle", w), 80'(cyc), 80'(x.due));
      end
    end else begin
      check($sformatf("dut%0d idle outputs", w), 80'({r.addr_ok, e, r.data}), 80'd0);
    end
    prev_ok[w] = r.data_ok;
  endtask

  always @(negedge clk) begin
    mon(0, dresp0, err0);
    mon(1, dresp1, err1);
  end

  task automatic drive(input int w, input logic [63:0] addr, input msize_t size,
                       input logic [7:0] strb, input logic [63:0] wdata);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = size;
    r.strobe = strb;
    r.data   = wdata;
    if (w == 0) dreq0 = r;
    else        dreq1 = r;
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic xfer(input int w, input logic [63:0] addr, input msize_t size,
                      input logic [7:0] strb, input logic [63:0] wdata,
                      input logic [63:0] exp_data, input logic exp_err);
    exp_t x;
    logic seen;
    x.data = exp_data;
    x.err  = exp_err;
    x.due  = cyc + ((w == 0) ? 2 : 1);
    if (w == 0) q0.push_back(x);
    else        q1.push_back(x);
    drive(w, addr, size, strb, wdata);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (w == 0) ? dresp0.data_ok : dresp1.data_ok;
    end
    if (!seen) check($sformatf("dut%0d xfer timeout", w), 80'(seen), 80'd1);
    if (w == 0) dreq0.valid = 1'b0;
    else        dreq1.valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t x;
    logic seen;
    int   n;
    int   hits;
    reset = 1'b1;
    dreq0 = '0;
    dreq1 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs dut0", 80'({dresp0, err0}), 80'd0);
    check("reset outputs dut1", 80'({dresp1, err1}), 80'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full write then read back
    xfer(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
    xfer(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);

    // Partial write on a word preloaded with all ones
    xfer(0, 64'h8000_0018, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    xfer(0, 64'h8000_0018, MSIZE4, 8'h0F, 64'h0, 64'h0, 1'b0);
    xfer(0, 64'h8000_0018, MSIZE8, 8'h00, 64'h0, 64'hFFFF_FFFF_0000_0000, 1'b0);

    // Below base, misaligned write leaves the target untouched
    xfer(0, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1);
    xfer(0, 64'h8000_0000, MSIZE8, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 1'b0);
    xfer(0, 64'h8000_0002, MSIZE4, 8'h3C, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1);
    xfer(0, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);

    // Top boundary: last word legal, one past it faulty
    xfer(0, 64'h8000_1FF8, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 1'b0);
    xfer(0, 64'h8000_1FF8, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    xfer(0, 64'h8000_2000, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1);

    // Misaligned halfword read faults; byte read returns the whole word
    xfer(0, 64'h8000_0011, MSIZE2, 8'h00, 64'h0, 64'h0, 1'b1);
    xfer(0, 64'h8000_0013, MSIZE1, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);

    // Flush: valid dropped during WAIT, no response, memory unchanged
    drive(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD);
    @(negedge clk);
    dreq0.valid = 1'b0;
    repeat (3) @(negedge clk);
    xfer(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);

    // Reset during WAIT of a write: write must be dropped
    drive(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset mid-wait outputs", 80'({dresp0, err0}), 80'd0);
    dreq0.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xfer(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);

    // Reset during RESP: outputs must clear before the next clock edge
    x.data = 64'hFFFF_FFFF_0000_0000;
    x.err  = 1'b0;
    x.due  = cyc + 2;
    q0.push_back(x);
    drive(0, 64'h8000_0018, MSIZE8, 8'h00, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dresp0.data_ok;
    end
    if (!seen) check("resp before reset timeout", 80'(seen), 80'd1);
    dreq0.valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("reset in resp outputs", 80'({dresp0, err0}), 80'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Memory survives reset
    xfer(0, 64'h8000_0018, MSIZE8, 8'h00, 64'h0, 64'hFFFF_FFFF_0000_0000, 1'b0);

    // LATENCY=1: preload, then five back-to-back reads with valid held high
    xfer(1, 64'h8000_0040, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
    n = cyc;
    for (int k = 0; k < 5; k++) begin
      x.data = 64'h0123_4567_89AB_CDEF;
      x.err  = 1'b0;
      x.due  = n + 1 + 2 * k;
      q1.push_back(x);
    end
    drive(1, 64'h8000_0040, MSIZE8, 8'h00, 64'h0);
    hits = 0;
    for (int i = 0; i < 20 && hits < 5; i++) begin
      @(negedge clk);
      if (dresp1.data_ok) hits++;
    end
    check("b2b response count", 80'(hits), 80'd5);
    dreq1.valid = 1'b0;
    repeat (3) @(negedge clk);

    check("dut0 scoreboard drained", 80'(q0.size()), 80'd0);
    check("dut1 scoreboard drained", 80'(q1.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h8000_0000: byte address of memory word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: number of 64-bit words; power of two.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to data_ok; legal range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port dreq  input  dbus_req_t  fields valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0], from the core's memory stage.
REQ-007 SHALL have port dresp  output  dbus_resp_t  fields addr_ok, data_ok, data[63:0].
REQ-008 SHALL have port err  output  1  one-cycle pulse alongside data_ok when the completed access was faulty.

Function
REQ-009 SHALL implement states IDLE, WAIT, RESP.
REQ-010 IDLE: dreq.valid=1 SHALL latch addr, size, strobe, data, load a 4-bit counter with LATENCY-1 and go to WAIT, or go directly to RESP when LATENCY=1.
REQ-011 IDLE with dreq.valid=0 SHALL remain in IDLE, with every output at 0.
REQ-012 WAIT: counter decrements each cycle; at 0 the state SHALL go to RESP.
REQ-013 WAIT with dreq.valid=0 (initiator flush): SHALL return to IDLE with no memory write and no response.
REQ-014 RESP: SHALL assert addr_ok=1 and data_ok=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-015 dreq.valid in the RESP cycle SHALL NOT be sampled as a new request; next request is accepted no earlier than the following IDLE cycle (max throughput one access per LATENCY+1 cycles).
REQ-016 Word index SHALL be (addr - BASE_ADDR) >> 3, truncated to log2(MEM_WORDS) bits after range check.
REQ-017 Access is faulty if addr < BASE_ADDR or addr >= BASE_ADDR + 8*MEM_WORDS, or if misaligned: MSIZE2 with addr[0]!=0, MSIZE4 with addr[1:0]!=0, MSIZE8 with addr[2:0]!=0.
REQ-018 Read (strobe=0): dresp.data in RESP SHALL be the full aligned 64-bit word; the initiator performs lane extraction.
REQ-019 Write (strobe!=0): in the RESP cycle, byte lane i SHALL be written with data[8i+7:8i] where strobe[i]=1; other lanes unchanged; dresp.data SHALL be 0.
REQ-020 Faulty access: no write; dresp.data=0; err=1 in the RESP cycle; data_ok still asserted so the initiator never hangs.
REQ-021 Read sampling SHALL occur in the RESP cycle, so a read directly following a write to the same word returns the written value.
REQ-022 Outputs SHALL be registered from state only; no combinational path from dreq to dresp or err.

Reset
REQ-023 Asserting reset at any time, including mid-WAIT, SHALL force IDLE, counter 0, addr_ok=data_ok=err=0, dresp.data=0 immediately, without waiting for clk.
REQ-024 A write pending in WAIT when reset asserts SHALL NOT reach memory.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-026 Write then read, LATENCY=2: write addr 8000_0010, MSIZE8, strobe FF, data 1122334455667788 -> data_ok two cycles after acceptance; then read same addr -> data 1122334455667788, err=0.
REQ-027 Partial write: word preloaded FFFF_FFFF_FFFF_FFFF; write strobe 0F, data 0 -> read returns FFFF_FFFF_0000_0000.
REQ-028 Faults: read addr 7FFF_FFF8 -> data_ok=1, err=1, data=0; write MSIZE4 addr 8000_0002 -> err=1, target word unchanged.
REQ-029 Flush: write accepted, dreq.valid dropped during WAIT -> no data_ok, state IDLE, memory unchanged; next request serviced normally.
REQ-030 Reset mid-WAIT on a write: reset pulsed -> outputs 0 asynchronously, subsequent read shows old contents.
REQ-031 Back-to-back reads, LATENCY=1, valid held high: data_ok every second cycle, addr_ok/data_ok never high two consecutive cycles.
